mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, max cycles spent in WAIT before the transaction is aborted.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0, req1  input  1 each  requester 0/1 request; held high until the matching ack.
REQ-005 a0, b0, a1, b1  input  4 each  requester operands (unsigned).
REQ-006 ack0, ack1  output  1 each  one-cycle completion pulse to the requester.
REQ-007 err0, err1  output  1 each  one-cycle timeout flag, coincident with ack.
REQ-008 p0, p1  output  8 each  registered product per requester.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 mult_start  output  1  one-cycle start pulse to the shared sequential multiplier.
REQ-011 mult_a, mult_b  output  4 each  latched operands driven to the multiplier.
REQ-012 mult_done  input  1  multiplier completion strobe.
REQ-013 mult_p  input  8  multiplier product, valid while mult_done is high.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT and RESP, with exactly one active.
REQ-015 IDLE: at an edge with req0 or req1 high, go to ISSUE and record the granted index g.
REQ-016 Arbitration SHALL be round-robin on pointer last: if both requests are high, grant the index != last; otherwise grant the single requester.
REQ-017 The arbiter SHALL update last to g on the IDLE->ISSUE transition.
REQ-018 On the IDLE->ISSUE edge, a_g and b_g SHALL be latched into mult_a/mult_b and held until the next grant.
REQ-019 Operand changes after the latch edge SHALL be ignored.
REQ-020 ISSUE: mult_start is high for exactly this one cycle, then the FSM goes to WAIT unconditionally.
REQ-021 WAIT: a 4-bit counter SHALL clear on entry and increment each cycle.
REQ-022 WAIT, mult_done high at an edge: capture mult_p into p_g and go to RESP.
REQ-023 WAIT, counter reaching TIMEOUT with mult_done low: set p_g = 0, set the error flag and go to RESP.
REQ-024 If mult_done and the timeout occur at the same edge, mult_done SHALL win and no error is raised.
REQ-025 RESP: ack_g is high for this one cycle, and err_g is high only if the error flag is set; the FSM then returns to IDLE.
REQ-026 ack and err for the non-granted index SHALL stay low.
REQ-027 mult_done outside WAIT SHALL be ignored.
REQ-028 p0/p1 SHALL hold their value until overwritten by a later completion on the same index.
REQ-029 Latency: req edge N gives mult_start during cycle N+1; done at edge M gives ack during cycle M+1.
REQ-030 Minimum request-to-ack SHALL be 3 cycles when done arrives on the first WAIT edge.
REQ-031 A request dropped while IDLE before being granted SHALL be ignored; a request dropped after the grant SHALL still complete and ack.
REQ-032 A request still high after its ack SHALL be a new request, and the other requester wins if it is pending.
REQ-033 Product width: 4x4 unsigned gives 8 bits; mult_p SHALL be passed through unmodified.

Reset
REQ-034 While rst is high, regardless of clk: state = IDLE and last = 1, so req0 wins the first tie.
REQ-035 While rst is high: mult_start, mult_a, mult_b, ack0/1, err0/1, p0/1, busy and the counter SHALL all be 0.
REQ-036 A rst asserted mid-transaction (ISSUE/WAIT/RESP) SHALL abort it with no ack, and the pending request re-arbitrates after release.

Verification
REQ-037 req0 with a0=1, b0=3; the model returns done with 3 after 4 cycles -> one mult_start with mult_a=1, mult_b=3; ack0 pulses once; p0=3; err0=0.
REQ-038 Both requests high in the first cycle after reset, with a0=b0=15 and a1=9, b1=3 -> req0 served first with p0=225, then req1 with p1=27; two mult_start pulses total.
REQ-039 Both requests held high for 4 transactions -> grant order 0,1,0,1; busy drops for exactly one IDLE cycle between transactions.
REQ-040 req1 with a1=13, b1=12 and a1 changed to 0 after the grant -> mult_a stays 13; p1=156.
REQ-041 mult_done never asserted -> ack0 and err0 pulse after 15 WAIT cycles; p0=0; the FSM returns to IDLE.
REQ-042 rst pulsed for 20 ns during WAIT, then done asserted after release -> no ack, all outputs zero; the held req is regranted and the late done is ignored.

Source files
------------

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin arbiter sharing one sequential 4x4 multiplier
//               between two requesters, with a WAIT-state timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       ack0,
    output logic       ack1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] p0,
    output logic [7:0] p1,
    output logic       busy,
    output logic       mult_start,
    output logic [3:0] mult_a,
    output logic [3:0] mult_b,
    input  logic       mult_done,
    input  logic [7:0] mult_p
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    // The timeout fires on the edge where the counter would reach TIMEOUT.
    localparam logic [3:0] c_CNT_LAST = 4'(TIMEOUT - 1);

    logic [1:0] r_state;
    logic       r_last;
    logic       r_g;
    logic [3:0] r_cnt;
    logic       w_grant;

    // On a tie the requester that was not served last wins.
    assign w_grant = (req0 && req1) ? ~r_last : ~req0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_last     <= 1'b1;
            r_g        <= 1'b0;
            r_cnt      <= 4'd0;
            mult_start <= 1'b0;
            mult_a     <= 4'd0;
            mult_b     <= 4'd0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            p0         <= 8'd0;
            p1         <= 8'd0;
            busy       <= 1'b0;
        end else begin
            mult_start <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (req0 || req1) begin
                        r_state    <= c_ISSUE;
                        r_g        <= w_grant;
                        r_last     <= w_grant;
                        mult_a     <= w_grant ? a1 : a0;
                        mult_b     <= w_grant ? b1 : b0;
                        mult_start <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                c_ISSUE: begin
                    r_state <= c_WAIT;
                    r_cnt   <= 4'd0;
                end
                c_WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    // A completion on the timeout edge takes priority.
                    if (mult_done) begin
                        r_state <= c_RESP;
                        if (r_g) begin
                            p1   <= mult_p;
                            ack1 <= 1'b1;
                        end else begin
                            p0   <= mult_p;
                            ack0 <= 1'b1;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_RESP;
                        if (r_g) begin
                            p1   <= 8'd0;
                            ack1 <= 1'b1;
                            err1 <= 1'b1;
                        end else begin
                            p0   <= 8'd0;
                            ack0 <= 1'b1;
                            err0 <= 1'b1;
                        end
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Directed self-checking bench for mult_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic       ack0, ack1, err0, err1;
    logic [7:0] p0, p1;
    logic       busy, mult_start;
    logic [3:0] mult_a, mult_b;
    logic       mult_done;
    logic [7:0] mult_p;

    int checks   = 0;
    int failures = 0;
    int n_start  = 0;
    int n_ref;

    mult_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .p0(p0), .p1(p1), .busy(busy),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .mult_p(mult_p)
    );

    always #5 clk = ~clk;

    // Each start pulse spans a full cycle, so one negedge sample per pulse.
    always @(negedge clk) if (mult_start) n_start++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serve one granted transaction: done is raised dly cycles after the start cycle.
    task automatic xact(input int g, input logic [3:0] ea, input logic [3:0] eb,
                        input int dly, input logic [7:0] prod, input string tag);
        int i = 0;
        while (!mult_start && i < 20) begin
            @(negedge clk);
            i++;
        end
        check({tag, " start"}, mult_start, 1);
        check({tag, " mult_a"}, mult_a, ea);
        check({tag, " mult_b"}, mult_b, eb);
        @(negedge clk);
        check({tag, " start_one_cycle"}, mult_start, 0);
        repeat (dly - 1) @(negedge clk);
        mult_done = 1'b1;
        mult_p    = prod;
        @(negedge clk);
        mult_done = 1'b0;
        mult_p    = 8'd0;
        check({tag, " ack_g"}, (g == 0) ? ack0 : ack1, 1);
        check({tag, " ack_other"}, (g == 0) ? ack1 : ack0, 0);
        check({tag, " err_g"}, (g == 0) ? err0 : err1, 0);
        check({tag, " p_g"}, (g == 0) ? p0 : p1, prod);
    endtask

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        mult_done = 0; mult_p = 0;
        @(negedge clk); @(negedge clk);
        check("rst busy", busy, 0);
        check("rst start", mult_start, 0);
        check("rst mult_a", mult_a, 0);
        check("rst p0", p0, 0);
        check("rst ack0", ack0, 0);

        // Single request, done 4 cycles after start
        rst = 1'b0;
        req0 = 1; a0 = 1; b0 = 3;
        xact(0, 4'd1, 4'd3, 4, 8'd3, "single");
        req0 = 0;
        @(negedge clk);
        check("single ack_drop", ack0, 0);
        check("single idle", busy, 0);

        // Tie right after reset: req0 first
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_ref = n_start;
        req0 = 1; req1 = 1; a0 = 15; b0 = 15; a1 = 9; b1 = 3;
        xact(0, 4'd15, 4'd15, 2, 8'd225, "tie0");
        req0 = 0;
        xact(1, 4'd9, 4'd3, 2, 8'd27, "tie1");
        req1 = 0;
        @(negedge clk);
        @(negedge clk);
        check("tie start_count", n_start - n_ref, 2);

        // Both held: alternating grants, one IDLE cycle between
        req0 = 1; req1 = 1; a0 = 2; b0 = 3; a1 = 4; b1 = 5;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) xact(0, 4'd2, 4'd3, 1, 8'd6, "rr0");
            else            xact(1, 4'd4, 4'd5, 1, 8'd20, "rr1");
            if (k == 3) begin req0 = 0; req1 = 0; end
            @(negedge clk);
            check("rr idle_gap", busy, 0);
        end

        // Operand change after grant is ignored
        req1 = 1; a1 = 13; b1 = 12;
        @(negedge clk);
        a1 = 0;
        xact(1, 4'd13, 4'd12, 3, 8'd156, "latch");
        req1 = 0;
        check("latch mult_a_held", mult_a, 13);
        check("latch p0_held", p0, 6);

        // Timeout with no done
        @(negedge clk);
        req0 = 1; a0 = 7; b0 = 7;
        @(negedge clk);
        check("to start", mult_start, 1);
        repeat (15) @(negedge clk);
        check("to no_ack_early", ack0, 0);
        @(negedge clk);
        check("to ack0", ack0, 1);
        check("to err0", err0, 1);
        check("to p0", p0, 0);
        check("to ack1", ack1, 0);
        req0 = 0;
        @(negedge clk);
        check("to idle", busy, 0);

        // Done on the timeout edge wins
        req1 = 1; a1 = 10; b1 = 9;
        xact(1, 4'd10, 4'd9, 15, 8'd90, "race");
        req1 = 0;
        @(negedge clk);

        // Reset during WAIT, held request re-granted, late done ignored
        req0 = 1; a0 = 5; b0 = 6;
        @(negedge clk);
        check("abort start", mult_start, 1);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort mult_a", mult_a, 0);
        check("abort mult_b", mult_b, 0);
        check("abort p1", p1, 0);
        check("abort ack0", ack0, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        mult_done = 1; mult_p = 8'hAA;
        @(negedge clk);
        check("abort regrant", mult_start, 1);
        check("abort regrant_a", mult_a, 5);
        @(negedge clk);
        mult_done = 0; mult_p = 0;
        check("abort late_done_ack", ack0, 0);
        check("abort late_done_p0", p0, 0);
        check("abort waiting", busy, 1);
        @(negedge clk);
        mult_done = 1; mult_p = 8'd30;
        @(negedge clk);
        mult_done = 0; mult_p = 0;
        check("abort ack0_final", ack0, 1);
        check("abort err0_final", err0, 0);
        check("abort p0_final", p0, 30);
        req0 = 0;
        @(negedge clk);
        check("abort idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
